// File: rtl/dmem_responder.sv
// Data-memory responder for the EX/MEM stage: one load/store in flight at a time,
// fixed access latency, one-cycle response strobe and a combinational stall.
module dmem_responder #(
  parameter int DEPTH_WORDS = 256,
  parameter int LATENCY     = 2
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_req_valid,
  input  logic        i_req_write,
  input  logic [31:0] i_req_addr,
  input  logic [31:0] i_req_wdata,
  output logic        o_req_ready,
  output logic        o_rsp_valid,
  output logic [31:0] o_rsp_rdata,
  output logic        o_rsp_err,
  output logic        o_stall
);

  localparam int         AW      = $clog2(DEPTH_WORDS);
  localparam logic [3:0] LAT_CNT = 4'(LATENCY);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [3:0]      r_cnt;
  logic [3:0]      w_cnt_nxt;
  logic            r_write;
  logic [AW-1:0]   r_idx;
  logic [31:0]     r_wdata;
  logic [31:0]     r_mem [DEPTH_WORDS];
  logic            r_req_ready;
  logic            r_rsp_valid;
  logic [31:0]     r_rsp_rdata;
  logic            r_rsp_err;

  logic            w_misalign;
  logic            w_access;
  logic            w_acc_write;
  logic [AW-1:0]   w_acc_idx;
  logic [31:0]     w_acc_wdata;
  logic [31:0]     w_rdata_nxt;
  logic            w_err_nxt;

  // Bits above the word index are deliberately ignored (address aliasing).
  logic w_unused_addr;
  assign w_unused_addr = ^i_req_addr[31:AW+2];

  assign w_misalign = (i_req_addr[1:0] != 2'b00);

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_access    = 1'b0;
    w_acc_write = r_write;
    w_acc_idx   = r_idx;
    w_acc_wdata = r_wdata;
    w_rdata_nxt = 32'd0;
    w_err_nxt   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (i_req_valid) begin
          if (w_misalign) begin
            w_state_nxt = ST_RESP;
            w_err_nxt   = 1'b1;
          end else if (LATENCY == 0) begin
            // Zero latency: the access happens on the acceptance edge using the live payload.
            w_state_nxt = ST_RESP;
            w_access    = 1'b1;
            w_acc_write = i_req_write;
            w_acc_idx   = i_req_addr[AW+1:2];
            w_acc_wdata = i_req_wdata;
          end else begin
            w_state_nxt = ST_BUSY;
            w_cnt_nxt   = LAT_CNT - 4'd1;
          end
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_BUSY: begin
        if (r_cnt == 4'd0) begin
          w_state_nxt = ST_RESP;
          w_access    = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt - 4'd1;
        end
      end
      ST_RESP: begin
        w_state_nxt = ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_cnt_nxt   = 4'd0;
      end
    endcase
    if (w_access && !w_acc_write) begin
      w_rdata_nxt = r_mem[w_acc_idx];
    end else begin
      w_rdata_nxt = 32'd0;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state     <= ST_IDLE;
      r_cnt       <= 4'd0;
      r_req_ready <= 1'b1;
      r_rsp_valid <= 1'b0;
      r_rsp_rdata <= 32'd0;
      r_rsp_err   <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_cnt       <= w_cnt_nxt;
      r_req_ready <= (w_state_nxt == ST_IDLE);
      r_rsp_valid <= (w_state_nxt == ST_RESP);
      r_rsp_rdata <= w_rdata_nxt;
      r_rsp_err   <= w_err_nxt;
    end
  end

  // Payload copy taken at acceptance; later changes on the request lines are ignored.
  always_ff @(posedge i_clk) begin
    if (!i_rst && r_state == ST_IDLE && i_req_valid) begin
      r_write <= i_req_write;
      r_idx   <= i_req_addr[AW+1:2];
      r_wdata <= i_req_wdata;
    end
  end

  // Backing store is not reset; a store whose commit edge sees reset is dropped.
  always_ff @(posedge i_clk) begin
    if (!i_rst && w_access && w_acc_write) begin
      r_mem[w_acc_idx] <= w_acc_wdata;
    end
  end

  assign o_req_ready = r_req_ready;
  assign o_rsp_valid = r_rsp_valid;
  assign o_rsp_rdata = r_rsp_rdata;
  assign o_rsp_err   = r_rsp_err;
  assign o_stall     = (r_state == ST_IDLE && i_req_valid) || (r_state == ST_BUSY);

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: one instance at LATENCY=2, one at LATENCY=0.
module tb_dmem_responder;

  logic        clk = 1'b0;
  logic        rst;
  always #5 clk = ~clk;

  logic        v2, w2, rdy2, rv2, err2, st2;
  logic [31:0] a2, d2, rd2;
  logic        v0, w0, rdy0, rv0, err0, st0;
  logic [31:0] a0, d0, rd0;

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;

  dmem_responder #(.DEPTH_WORDS(256), .LATENCY(2)) u_lat2 (
    .i_clk(clk), .i_rst(rst), .i_req_valid(v2), .i_req_write(w2),
    .i_req_addr(a2), .i_req_wdata(d2), .o_req_ready(rdy2), .o_rsp_valid(rv2),
    .o_rsp_rdata(rd2), .o_rsp_err(err2), .o_stall(st2)
  );

  dmem_responder #(.DEPTH_WORDS(256), .LATENCY(0)) u_lat0 (
    .i_clk(clk), .i_rst(rst), .i_req_valid(v0), .i_req_write(w0),
    .i_req_addr(a0), .i_req_wdata(d0), .o_req_ready(rdy0), .o_rsp_valid(rv0),
    .o_rsp_rdata(rd0), .o_rsp_err(err0), .o_stall(st0)
  );

  task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic check1(input string tag, input logic obs, input logic exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  // Full transaction on the LATENCY=2 instance; exp_wait = cycles from acceptance to strobe.
  task automatic req2(input string tag, input logic wr, input logic [31:0] addr,
                      input logic [31:0] wdata, input logic [31:0] exp_rdata,
                      input logic exp_err, input int exp_wait);
    int n;
    @(negedge clk);
    v2 = 1'b1; w2 = wr; a2 = addr; d2 = wdata;
    #1;
    check1({tag, "/stall_req"}, st2, 1'b1);
    check1({tag, "/ready_idle"}, rdy2, 1'b1);
    @(posedge clk);
    @(negedge clk);
    n = 0;
    while (rv2 !== 1'b1 && n < 20) begin
      check1({tag, "/stall_busy"}, st2, 1'b1);
      @(negedge clk);
      n++;
    end
    check32({tag, "/wait"}, 32'(n), 32'(exp_wait));
    check32({tag, "/rdata"}, rd2, exp_rdata);
    check1({tag, "/err"}, err2, exp_err);
    check1({tag, "/stall_resp"}, st2, 1'b0);
    check1({tag, "/ready_resp"}, rdy2, 1'b0);
    v2 = 1'b0;
    @(negedge clk);
    check1({tag, "/strobe_once"}, rv2, 1'b0);
    check1({tag, "/ready_back"}, rdy2, 1'b1);
  endtask

  logic [31:0] lat0_data [3];

  initial begin
    lat0_data[0] = 32'h1111_1111;
    lat0_data[1] = 32'h2222_2222;
    lat0_data[2] = 32'h3333_3333;
    rst = 1'b1;
    v2 = 1'b0; w2 = 1'b0; a2 = 32'd0; d2 = 32'd0;
    v0 = 1'b0; w0 = 1'b0; a0 = 32'd0; d0 = 32'd0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check1("rst/ready", rdy2, 1'b1);
    check1("rst/rsp_valid", rv2, 1'b0);
    check1("rst/stall", st2, 1'b0);
    check32("rst/rdata", rd2, 32'd0);
    check1("rst/err", err2, 1'b0);
    check1("rst0/ready", rdy0, 1'b1);
    check1("rst0/rsp_valid", rv0, 1'b0);
    rst = 1'b0;

    req2("st10", 1'b1, 32'h10, 32'hDEAD_BEEF, 32'd0, 1'b0, 2);
    req2("ld10", 1'b0, 32'h10, 32'd0, 32'hDEAD_BEEF, 1'b0, 2);
    req2("mis13", 1'b0, 32'h13, 32'd0, 32'd0, 1'b1, 0);
    req2("mis13_st", 1'b1, 32'h13, 32'h5555_5555, 32'd0, 1'b1, 0);
    req2("ld10_again", 1'b0, 32'h10, 32'd0, 32'hDEAD_BEEF, 1'b0, 2);
    req2("st400", 1'b1, 32'h400, 32'h1234_5678, 32'd0, 1'b0, 2);
    req2("ld000", 1'b0, 32'h0, 32'd0, 32'h1234_5678, 1'b0, 2);
    req2("st3fc", 1'b1, 32'h3FC, 32'hA5A5_A5A5, 32'd0, 1'b0, 2);
    req2("ld3fc", 1'b0, 32'h3FC, 32'd0, 32'hA5A5_A5A5, 1'b0, 2);
    req2("ld7fc_alias", 1'b0, 32'h7FC, 32'd0, 32'hA5A5_A5A5, 1'b0, 2);
    req2("ld000_intact", 1'b0, 32'h0, 32'd0, 32'h1234_5678, 1'b0, 2);

    // Reset one edge after accepting a store: store must be abandoned.
    req2("st20_prior", 1'b1, 32'h20, 32'h0BAD_F00D, 32'd0, 1'b0, 2);
    @(negedge clk);
    v2 = 1'b1; w2 = 1'b1; a2 = 32'h20; d2 = 32'hCAFE_F00D;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1; v2 = 1'b0;
    @(negedge clk);
    check1("rstbusy/rsp_valid", rv2, 1'b0);
    check1("rstbusy/ready", rdy2, 1'b1);
    check1("rstbusy/stall", st2, 1'b0);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check1("rstbusy/no_rsp", rv2, 1'b0);
    end
    req2("ld20_after_rst", 1'b0, 32'h20, 32'd0, 32'h0BAD_F00D, 1'b0, 2);

    // Reset exactly on the commit edge: store must not land.
    @(negedge clk);
    v2 = 1'b1; w2 = 1'b1; a2 = 32'h20; d2 = 32'hFEED_FACE;
    @(posedge clk);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1; v2 = 1'b0;
    @(negedge clk);
    check1("rstcommit/rsp_valid", rv2, 1'b0);
    check1("rstcommit/ready", rdy2, 1'b1);
    rst = 1'b0;
    req2("ld20_after_commit_rst", 1'b0, 32'h20, 32'd0, 32'h0BAD_F00D, 1'b0, 2);

    // LATENCY=0 back-to-back: valid stays high, store/load alternate on address 0x8.
    @(negedge clk);
    v0 = 1'b1; w0 = 1'b1; a0 = 32'h8; d0 = lat0_data[0];
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check1("lat0/st_rsp", rv0, 1'b1);
      check1("lat0/st_stall", st0, 1'b0);
      check1("lat0/st_ready", rdy0, 1'b0);
      check1("lat0/st_err", err0, 1'b0);
      check32("lat0/st_rdata", rd0, 32'd0);
      w0 = 1'b0;
      @(negedge clk);
      check1("lat0/gap_rsp", rv0, 1'b0);
      check1("lat0/gap_ready", rdy0, 1'b1);
      check1("lat0/gap_stall", st0, 1'b1);
      @(negedge clk);
      check1("lat0/ld_rsp", rv0, 1'b1);
      check1("lat0/ld_stall", st0, 1'b0);
      check32("lat0/ld_rdata", rd0, lat0_data[i]);
      if (i < 2) begin
        w0 = 1'b1; d0 = lat0_data[i+1];
      end else begin
        v0 = 1'b0;
      end
      @(negedge clk);
      check1("lat0/gap2_rsp", rv0, 1'b0);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
